// File: rtl/arm1_out_queue.sv
// rtl/arm1_out_queue.sv - show-ahead output FIFO capturing ARM1 O-register writes (option: ARM1_OUT_DROP_CNT_EN)
module arm1_out_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       o_write,
    input  logic [DATA_W-1:0]          o_in,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
`ifdef ARM1_OUT_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    input  logic                       clr_overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_next;
    logic              pop;
    logic              push;
    logic              drop;

    // A pop at full frees the slot the same-cycle push lands in, so push is
    // accepted whenever a pop happens; only an unpopped write at full drops.
    always_comb begin
        pop        = !empty && out_ready;
        push       = o_write && (!full || pop);
        drop       = o_write && full && !pop;
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // Storage is written without reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= o_in;
        end
    end

    // Pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Sticky drop flag; a new drop in the clearing cycle keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef ARM1_OUT_DROP_CNT_EN
    // Saturating drop counter sharing the clear/set-wins rule of overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 8'd0;
        end else if (drop) begin
            if (clr_overflow) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clr_overflow) begin
            drop_cnt <= 8'd0;
        end
    end
`endif

    // Show-ahead head of queue; zero whenever nothing is queued.
    always_comb begin
        out_valid = !empty;
        out_data  = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: tb/tb_arm1_out_queue.sv
// tb/tb_arm1_out_queue.sv - directed self-checking bench for arm1_out_queue
module tb_arm1_out_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       o_write;
    logic [7:0] o_in;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_overflow;
`ifdef ARM1_OUT_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int passed = 0;
    int total  = 0;

    arm1_out_queue #(.DEPTH(4), .DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .o_write      (o_write),
        .o_in         (o_in),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
`ifdef ARM1_OUT_DROP_CNT_EN
        .drop_cnt     (drop_cnt),
`endif
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; o_write = 1'b0; o_in = 8'h00; out_ready = 1'b0; clr_overflow = 1'b0;
        step(); step();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %h exp 0", out_valid); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL rst_data got %h exp 00", out_data); else passed++;
        total++; if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
        total++; if (full !== 1'b0) $display("FAIL rst_full got %h exp 0", full); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL rst_empty got %h exp 1", empty); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %h exp 0", overflow); else passed++;
    endtask

    task automatic test_single_push();
        o_write = 1'b1; o_in = 8'h5A;
        step();
        o_write = 1'b0; o_in = 8'hC3;
        total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %h exp 1", out_valid); else passed++;
        total++; if (out_data !== 8'h5A) $display("FAIL single_data got %h exp 5a", out_data); else passed++;
        total++; if (count !== 3'd1) $display("FAIL single_count got %0d exp 1", count); else passed++;
        total++; if (empty !== 1'b0) $display("FAIL single_empty got %h exp 0", empty); else passed++;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_data !== 8'h5A || count !== 3'd1)
                $display("FAIL single_hold%0d got v=%h d=%h c=%0d exp v=1 d=5a c=1", i, out_valid, out_data, count);
            else passed++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (empty !== 1'b1 || out_data !== 8'h00) $display("FAIL single_drain got e=%h d=%h exp e=1 d=00", empty, out_data); else passed++;
    endtask

    task automatic test_fill_overflow();
        logic [7:0] exp_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            o_write = 1'b1; o_in = exp_q[i];
            step();
        end
        o_write = 1'b0;
        total++; if (full !== 1'b1 || count !== 3'd4) $display("FAIL fill_full got f=%h c=%0d exp f=1 c=4", full, count); else passed++;
        o_write = 1'b1; o_in = 8'h55;
        step();
        o_write = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %h exp 1", overflow); else passed++;
        total++; if (count !== 3'd4 || out_data !== 8'h11) $display("FAIL ovf_keep got c=%0d d=%h exp c=4 d=11", count, out_data); else passed++;
`ifdef ARM1_OUT_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd1) $display("FAIL ovf_dropcnt got %0d exp 1", drop_cnt); else passed++;
`endif
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %h exp 0", overflow); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== exp_q[i])
                $display("FAIL fill_drain%0d got v=%h d=%h exp v=1 d=%h", i, out_valid, out_data, exp_q[i]);
            else passed++;
            step();
        end
        out_ready = 1'b0;
        total++; if (empty !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00)
            $display("FAIL fill_empty got e=%h v=%h d=%h exp e=1 v=0 d=00", empty, out_valid, out_data);
        else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
        logic [7:0] fill_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            o_write = 1'b1; o_in = fill_q[i];
            step();
        end
        o_write = 1'b1; o_in = 8'h66; out_ready = 1'b1;
        step();
        o_write = 1'b0; out_ready = 1'b0;
        total++; if (count !== 3'd4 || full !== 1'b1) $display("FAIL fpp_count got c=%0d f=%h exp c=4 f=1", count, full); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fpp_ovf got %h exp 0", overflow); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_data !== exp_q[i]) $display("FAIL fpp_drain%0d got %h exp %h", i, out_data, exp_q[i]); else passed++;
            step();
        end
        out_ready = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL fpp_empty got %h exp 1", empty); else passed++;
    endtask

    task automatic test_empty_push_pop();
        o_write = 1'b1; o_in = 8'h77; out_ready = 1'b1;
        step();
        o_write = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h77 || count !== 3'd1)
            $display("FAIL epp got v=%h d=%h c=%0d exp v=1 d=77 c=1", out_valid, out_data, count);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow_clear_and_reset();
        for (int i = 0; i < 4; i++) begin
            o_write = 1'b1; o_in = 8'hA0 + 8'(i);
            step();
        end
        o_in = 8'hB0;
        step();
        total++; if (overflow !== 1'b1) $display("FAIL oc_set got %h exp 1", overflow); else passed++;
        o_in = 8'hB1; clr_overflow = 1'b1;
        step();
        o_write = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL oc_setwins got %h exp 1", overflow); else passed++;
`ifdef ARM1_OUT_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd1) $display("FAIL oc_dropcnt_setwins got %0d exp 1", drop_cnt); else passed++;
`endif
        step();
        clr_overflow = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL oc_clear got %h exp 0", overflow); else passed++;
`ifdef ARM1_OUT_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd0) $display("FAIL oc_dropcnt_clear got %0d exp 0", drop_cnt); else passed++;
`endif
        total++; if (count !== 3'd4 || out_data !== 8'hA0) $display("FAIL oc_keep got c=%0d d=%h exp c=4 d=a0", count, out_data); else passed++;
        o_write = 1'b1; o_in = 8'hB2;
        step();
        o_write = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (count !== 3'd3 || out_data !== 8'hA1 || overflow !== 1'b1)
            $display("FAIL pre_rst got c=%0d d=%h o=%h exp c=3 d=a1 o=1", count, out_data, overflow);
        else passed++;
        reset = 1'b1; o_write = 1'b1; o_in = 8'hEE;
        step();
        reset = 1'b0; o_write = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || overflow !== 1'b0 || empty !== 1'b1)
            $display("FAIL mid_rst got c=%0d v=%h d=%h o=%h e=%h exp c=0 v=0 d=00 o=0 e=1", count, out_valid, out_data, overflow, empty);
        else passed++;
        step();
        total++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL rst_push_ignored got v=%h c=%0d exp v=0 c=0", out_valid, count); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_overflow_clear_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
